// File: rtl/inst_aligner_pkg.sv
// Shared decode constants for the instruction aligner and its prefix scanner.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package inst_aligner_pkg;

   localparam int LINE_BYTES = 16;
   localparam int RING_BYTES = 32;

   // Legacy prefix bytes recognised by the scanner
   localparam logic [7:0] PFX_REP  = 8'hF3;
   localparam logic [7:0] PFX_SIZE = 8'h66;
   localparam logic [7:0] PFX_ES   = 8'h26;
   localparam logic [7:0] PFX_CS   = 8'h2E;
   localparam logic [7:0] PFX_SS   = 8'h36;
   localparam logic [7:0] PFX_DS   = 8'h3E;
   localparam logic [7:0] PFX_FS   = 8'h64;
   localparam logic [7:0] PFX_GS   = 8'h65;

   // Segment index; doubles as the bit position in segSEL
   typedef enum logic [2:0] {
      SEG_ES = 3'd0,
      SEG_CS = 3'd1,
      SEG_SS = 3'd2,
      SEG_DS = 3'd3,
      SEG_FS = 3'd4,
      SEG_GS = 3'd5
   } seg_e;

   // One-hot segment select for a byte; all zeros when it is not a segment prefix
   function automatic logic [5:0] seg_onehot(input logic [7:0] b);
      logic [5:0] oh;
      oh = '0;
      case (b)
         PFX_ES:  oh[SEG_ES] = 1'b1;
         PFX_CS:  oh[SEG_CS] = 1'b1;
         PFX_SS:  oh[SEG_SS] = 1'b1;
         PFX_DS:  oh[SEG_DS] = 1'b1;
         PFX_FS:  oh[SEG_FS] = 1'b1;
         PFX_GS:  oh[SEG_GS] = 1'b1;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/inst_aligner_prefix_scan.sv
// Scans up to three leading bytes for REP / operand-size / segment prefixes.
// Latency: purely combinational.
// Backpressure: none; caller gates the results with its own valid.
module prefix_scan
   import inst_aligner_pkg::*;
(
   input  logic [23:0] bytes_i,
   output logic        is_rep_o,
   output logic        is_size_o,
   output logic        is_seg_o,
   output logic [5:0]  seg_sel_o,
   output logic [3:0]  pref_size_o
);

   logic       stop;
   logic [7:0] cur;
   logic [5:0] seg;

   // Walk bytes in order; stop at the first non-prefix or a second prefix of a group already seen
   always_comb begin
      is_rep_o    = 1'b0;
      is_size_o   = 1'b0;
      is_seg_o    = 1'b0;
      seg_sel_o   = '0;
      pref_size_o = '0;
      stop        = 1'b0;
      cur         = '0;
      seg         = '0;
      for (int i = 0; i < 3; i++) begin
         cur = bytes_i[8*i +: 8];
         seg = seg_onehot(cur);
         if (!stop) begin
            if (cur == PFX_REP && !is_rep_o) begin
               is_rep_o    = 1'b1;
               pref_size_o = pref_size_o + 4'd1;
            end else if (cur == PFX_SIZE && !is_size_o) begin
               is_size_o   = 1'b1;
               pref_size_o = pref_size_o + 4'd1;
            end else if (seg != 6'd0 && !is_seg_o) begin
               is_seg_o    = 1'b1;
               seg_sel_o   = seg;
               pref_size_o = pref_size_o + 4'd1;
            end else begin
               stop = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/inst_aligner.sv
// Two-slot 32-byte byte queue presenting a 16-byte window at the instruction head, plus prefix decode.
// Latency: accept or take at edge N is visible on the window in cycle N+1; decode is combinational.
// Backpressure: line_ready drops when the tail slot is still occupied or during flush.
module inst_aligner
   import inst_aligner_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         line_valid,
   output logic         line_ready,
   input  logic [127:0] line_data,
   input  logic         flush,
   input  logic [3:0]   flush_off,
   output logic         out_valid,
   input  logic         dec_take,
   input  logic [3:0]   dec_len,
   output logic [127:0] win,
   output logic         isREP,
   output logic         isSIZE,
   output logic         isSEG,
   output logic [5:0]   segSEL,
   output logic [3:0]   prefSize,
   output logic [7:0]   B1,
   output logic [7:0]   B2,
   output logic [7:0]   B3
);

   logic [1:0]          slot_v_q, slot_v_d;
   logic [1:0][127:0]   slot_data_q, slot_data_d;
   logic [4:0]          head_q, head_d;
   logic                tail_q, tail_d;
   logic [3:0]          pend_off_q, pend_off_d;
   logic                pend_v_q, pend_v_d;

   logic [1:0]          nslots;
   logic [5:0]          occupancy;
   logic                accept, take;
   logic [4:0]          head_sum;
   logic [255:0]        ring;
   logic [4:0]          ring_idx;

   logic                scan_rep, scan_size, scan_seg;
   logic [5:0]          scan_seg_sel;
   logic [3:0]          scan_pref;
   logic [6:0]          b1_lsb, b2_lsb, b3_lsb;

   // Occupancy counts bytes from head to the end of the valid slots; handshake qualifiers
   always_comb begin
      nslots     = {1'b0, slot_v_q[0]} + {1'b0, slot_v_q[1]};
      occupancy  = slot_v_q[head_q[4]] ? ({nslots, 4'b0000} - {2'b00, head_q[3:0]}) : 6'd0;
      out_valid  = (occupancy >= 6'd16);
      line_ready = !slot_v_q[tail_q] && !flush;
      accept     = line_valid && line_ready;
      take       = dec_take && out_valid && (dec_len != 4'd0);
      head_sum   = head_q + {1'b0, dec_len};
   end

   // Next state: flush wins; otherwise take and accept both apply (they touch different slots)
   always_comb begin
      slot_v_d    = slot_v_q;
      slot_data_d = slot_data_q;
      head_d      = head_q;
      tail_d      = tail_q;
      pend_off_d  = pend_off_q;
      pend_v_d    = pend_v_q;
      if (flush) begin
         slot_v_d   = '0;
         tail_d     = 1'b0;
         head_d     = '0;
         pend_off_d = flush_off;
         pend_v_d   = 1'b1;
      end else begin
         if (take) begin
            head_d = head_sum;
            // Leaving a slot behind frees it for the next fetch line
            if (head_sum[4] != head_q[4]) begin
               slot_v_d[head_q[4]] = 1'b0;
            end
         end
         if (accept) begin
            slot_data_d[tail_q] = line_data;
            slot_v_d[tail_q]    = 1'b1;
            tail_d              = ~tail_q;
            // First line after a redirect starts at the branch target offset
            if (pend_v_q) begin
               head_d   = {tail_q, pend_off_q};
               pend_v_d = 1'b0;
            end
         end
      end
   end

   // State register with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_v_q    <= '0;
         slot_data_q <= '0;
         head_q      <= '0;
         tail_q      <= 1'b0;
         pend_off_q  <= '0;
         pend_v_q    <= 1'b0;
      end else begin
         slot_v_q    <= slot_v_d;
         slot_data_q <= slot_data_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         pend_off_q  <= pend_off_d;
         pend_v_q    <= pend_v_d;
      end
   end

   assign ring = slot_data_q;

   // Rotate the 32-byte ring so window byte 0 is the byte at head; indices wrap mod 32
   always_comb begin
      win      = '0;
      ring_idx = '0;
      for (int k = 0; k < LINE_BYTES; k++) begin
         ring_idx         = head_q + 5'(k);
         win[8*k +: 8]    = ring[{ring_idx, 3'b000} +: 8];
      end
   end

   prefix_scan u_prefix_scan (
      .bytes_i     (win[23:0]),
      .is_rep_o    (scan_rep),
      .is_size_o   (scan_size),
      .is_seg_o    (scan_seg),
      .seg_sel_o   (scan_seg_sel),
      .pref_size_o (scan_pref)
   );

   // Opcode bytes follow the prefixes; all decode fields read zero without a full window
   always_comb begin
      b1_lsb   = {scan_pref[3:0], 3'b000};
      b2_lsb   = b1_lsb + 7'd8;
      b3_lsb   = b1_lsb + 7'd16;
      isREP    = out_valid & scan_rep;
      isSIZE   = out_valid & scan_size;
      isSEG    = out_valid & scan_seg;
      segSEL   = out_valid ? scan_seg_sel : 6'd0;
      prefSize = out_valid ? scan_pref : 4'd0;
      B1       = out_valid ? win[b1_lsb +: 8] : 8'd0;
      B2       = out_valid ? win[b2_lsb +: 8] : 8'd0;
      B3       = out_valid ? win[b3_lsb +: 8] : 8'd0;
   end

endmodule
